// File: rtl/systolic_result_writer.sv
// Purpose: drains a captured 8x8 result tile to memory as 4-word row-half writes with per-lane masks.
// Latency: first write one cycle after start; full tile = 16 writes, done pulse the cycle after the last accept.
// Backpressure: write request and payload hold stable while mem_ready is low; each stall cycle adds one cycle.
module systolic_result_writer #(
    parameter int N          = 8,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [ADDR_WIDTH-1:0]                   base_C,
    input  logic [DIM_WIDTH-1:0]                    dim_col_C,
    input  logic [3:0]                              rows_valid,
    input  logic [3:0]                              cols_valid,
    input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]     Out,
    input  logic                                    mem_ready,
    output logic                                    write,
    output logic [ADDR_WIDTH-1:0]                   write_addr,
    output logic [LANES-1:0][DATA_WIDTH-1:0]        writedata,
    output logic [LANES-1:0]                        write_mask,
    output logic                                    busy,
    output logic                                    done
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] tile_t;
    typedef logic [LANES-1:0][DATA_WIDTH-1:0]    lanes_t;

    // Lane l of a row-half carries column half*LANES+l of the selected row.
    function automatic lanes_t pick_lanes(input tile_t t, input logic [2:0] row, input logic half);
        lanes_t     v;
        logic [2:0] col;
        for (int l = 0; l < LANES; l++) begin
            col  = 3'(int'(half) * LANES + l);
            v[l] = t[row][col];
        end
        return v;
    endfunction

    // A lane is enabled only while its column lies inside the valid column count.
    function automatic logic [LANES-1:0] lane_mask(input logic [3:0] cols, input logic half);
        logic [LANES-1:0] m;
        for (int l = 0; l < LANES; l++) begin
            m[l] = (4'(int'(half) * LANES + l) < cols);
        end
        return m;
    endfunction

    // Control and datapath state.
    state_t                  state_q;
    tile_t                   tile_q;
    logic [3:0]              row_q;
    logic                    half_q;
    logic [ADDR_WIDTH-1:0]   row_addr_q;
    logic [DIM_WIDTH-1:0]    dim_q;
    logic [3:0]              rows_q;
    logic [3:0]              cols_q;

    // Registered outputs.
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    lanes_t                  data_q;
    logic [LANES-1:0]        mask_q;
    logic                    busy_q;
    logic                    done_q;

    // Next-position and next-payload helpers.
    logic [3:0]              rows_clamp_d;
    logic [3:0]              cols_clamp_d;
    logic [3:0]              nxt_row_d;
    logic                    nxt_half_d;
    logic [ADDR_WIDTH-1:0]   nxt_row_addr_d;
    logic [ADDR_WIDTH-1:0]   nxt_addr_d;
    logic                    last_d;
    lanes_t                  nxt_lanes_d;
    logic [LANES-1:0]        nxt_mask_d;
    lanes_t                  first_lanes_d;
    logic [LANES-1:0]        first_mask_d;
    logic                    accept_start;

    assign accept_start = (state_q == IDLE) && start;

    // Compute the position after the current write is accepted, plus the payload for that position.
    always_comb begin
        rows_clamp_d   = (rows_valid > 4'(N)) ? 4'(N) : rows_valid;
        cols_clamp_d   = (cols_valid > 4'(N)) ? 4'(N) : cols_valid;
        nxt_half_d     = 1'b0;
        nxt_row_d      = row_q;
        nxt_row_addr_d = row_addr_q;
        if (!half_q && (cols_q > 4'(LANES))) begin
            nxt_half_d = 1'b1;
        end else begin
            nxt_row_d      = row_q + 4'd1;
            // Row addressing accumulates the stride; wraps naturally at ADDR_WIDTH.
            nxt_row_addr_d = row_addr_q + ADDR_WIDTH'(dim_q);
        end
        last_d        = (nxt_row_d == rows_q);
        nxt_addr_d    = nxt_row_addr_d + (nxt_half_d ? ADDR_WIDTH'(LANES) : '0);
        nxt_lanes_d   = pick_lanes(tile_q, nxt_row_d[2:0], nxt_half_d);
        nxt_mask_d    = lane_mask(cols_q, nxt_half_d);
        // The first write is built straight from the inputs since the buffer loads on the same edge.
        first_lanes_d = pick_lanes(Out, 3'd0, 1'b0);
        first_mask_d  = lane_mask(cols_clamp_d, 1'b0);
    end

    // Tile snapshot on an accepted start; deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && accept_start) begin
            tile_q <= Out;
        end
    end

    // Sequencer: IDLE -> WRITE (row-half walk) -> DONE, with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            row_q      <= '0;
            half_q     <= 1'b0;
            row_addr_q <= '0;
            dim_q      <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dim_q      <= dim_col_C;
                        rows_q     <= rows_clamp_d;
                        cols_q     <= cols_clamp_d;
                        row_q      <= '0;
                        half_q     <= 1'b0;
                        row_addr_q <= base_C;
                        busy_q     <= 1'b1;
                        if ((rows_clamp_d == 4'd0) || (cols_clamp_d == 4'd0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WRITE;
                            write_q <= 1'b1;
                            addr_q  <= base_C;
                            data_q  <= first_lanes_d;
                            mask_q  <= first_mask_d;
                        end
                    end
                end
                WRITE: begin
                    if (write_q && mem_ready) begin
                        row_q      <= nxt_row_d;
                        half_q     <= nxt_half_d;
                        row_addr_q <= nxt_row_addr_d;
                        if (last_d) begin
                            state_q <= DONE;
                            write_q <= 1'b0;
                            mask_q  <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= nxt_addr_d;
                            data_q  <= nxt_lanes_d;
                            mask_q  <= nxt_mask_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    write_q <= 1'b0;
                    mask_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign write      = write_q;
    assign write_addr = addr_q;
    assign writedata  = data_q;
    assign write_mask = mask_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_result_writer.sv
// Purpose: directed self-checking bench for systolic_result_writer.
// Latency: cycle numbers count from the edge that accepts start (cycle 1 = first write).
// Backpressure: mem_ready is driven per cycle by the bench to stall chosen writes.
module tb_systolic_result_writer;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int DMW = 16;
    localparam int L   = 4;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      start;
    logic [AW-1:0]             base_C;
    logic [DMW-1:0]            dim_col_C;
    logic [3:0]                rows_valid;
    logic [3:0]                cols_valid;
    logic [7:0][7:0][DW-1:0]   Out;
    logic                      mem_ready;
    logic                      write;
    logic [AW-1:0]             write_addr;
    logic [L-1:0][DW-1:0]      writedata;
    logic [L-1:0]              write_mask;
    logic                      busy;
    logic                      done;

    systolic_result_writer #(
        .N(8), .LANES(L), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .base_C(base_C),
        .dim_col_C(dim_col_C), .rows_valid(rows_valid), .cols_valid(cols_valid),
        .Out(Out), .mem_ready(mem_ready), .write(write), .write_addr(write_addr),
        .writedata(writedata), .write_mask(write_mask), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // Accepted-write log filled by collect().
    logic [AW-1:0]   wa [64];
    logic [L*DW-1:0] wd [64];
    logic [L-1:0]    wm [64];
    int              wc [64];
    int              n_wr;
    logic [AW-1:0]   sa [8];
    logic [L*DW-1:0] sd [8];
    int              n_st;
    int              done_cyc;
    logic            busy_after;
    logic            done_after;

    // Tile pattern Out[r][c] = r*8 + c + off.
    task automatic fill_out(input int off);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                Out[r][c] = DW'(r * 8 + c + off);
    endtask

    // Expected lanes for the r*8+c pattern: lane l = row*8 + half*4 + l.
    function automatic logic [L*DW-1:0] exp_data(input int row, input int half);
        logic [L*DW-1:0] v;
        for (int l = 0; l < L; l++) v[l*DW +: DW] = DW'(row * 8 + half * 4 + l);
        return v;
    endfunction

    // Called at #1 after an edge while the DUT is idle; returns in cycle 1.
    task automatic issue_start(input logic [AW-1:0] b, input logic [DMW-1:0] d,
                               input logic [3:0] rv, input logic [3:0] cv);
        base_C = b; dim_col_C = d; rows_valid = rv; cols_valid = cv;
        start = 1'b1; mem_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Run until done (bounded), logging accepted writes; optional stall and start pokes.
    task automatic collect(input int budget, input int stall_idx, input int stall_len,
                           input int poke_a, input int poke_b);
        int rem;
        rem = stall_len; n_wr = 0; n_st = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            start     = (cyc == poke_a) || (cyc == poke_b);
            mem_ready = 1'b1;
            if (write && n_wr == stall_idx && rem > 0) begin
                mem_ready = 1'b0;
                rem--;
                sa[n_st] = write_addr; sd[n_st] = writedata; n_st++;
            end
            if (write && mem_ready) begin
                wa[n_wr] = write_addr; wd[n_wr] = writedata; wm[n_wr] = write_mask;
                wc[n_wr] = cyc; n_wr++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (n_wr >= 64) break;
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        start = 1'b0; mem_ready = 1'b1;
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset;
        checks++; if (write !== 1'b0) $display("FAIL reset_write: got %0b want 0", write); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passed++;
        checks++; if (write_mask !== 4'b0000) $display("FAIL reset_mask: got %b want 0000", write_mask); else passed++;
        checks++; if (write_addr !== '0) $display("FAIL reset_addr: got %h want 0", write_addr); else passed++;
        checks++; if (writedata !== '0) $display("FAIL reset_data: got %h want 0", writedata); else passed++;
    endtask

    // Full 8x8 tile; Out is scrambled after start so only the captured copy may appear.
    task automatic test_full_tile;
        logic [AW-1:0] ea;
        fill_out(0);
        issue_start(32'h100, 16'd16, 4'd8, 4'd8);
        fill_out(16'h5000);
        collect(40, -1, 0, 0, 0);
        checks++; if (n_wr !== 16) $display("FAIL full_count: got %0d want 16", n_wr); else passed++;
        for (int i = 0; i < 16; i++) begin
            ea = 32'h100 + 32'((i / 2) * 16 + (i % 2) * 4);
            checks++; if (wa[i] !== ea) $display("FAIL full_addr[%0d]: got %h want %h", i, wa[i], ea); else passed++;
            checks++; if (wd[i] !== exp_data(i / 2, i % 2)) $display("FAIL full_data[%0d]: got %h want %h", i, wd[i], exp_data(i / 2, i % 2)); else passed++;
            checks++; if (wm[i] !== 4'b1111) $display("FAIL full_mask[%0d]: got %b want 1111", i, wm[i]); else passed++;
        end
        checks++; if (wc[0] !== 1) $display("FAIL full_first_cycle: got %0d want 1", wc[0]); else passed++;
        checks++; if (wc[15] !== 16) $display("FAIL full_last_cycle: got %0d want 16", wc[15]); else passed++;
        checks++; if (done_cyc !== 17) $display("FAIL full_done_cycle: got %0d want 17", done_cyc); else passed++;
        checks++; if (done_after !== 1'b0) $display("FAIL full_done_pulse: got %0b want 0", done_after); else passed++;
        checks++; if (busy_after !== 1'b0) $display("FAIL full_idle_busy: got %0b want 0", busy_after); else passed++;
    endtask

    // Three stall cycles on the second write.
    task automatic test_backpressure;
        fill_out(0);
        issue_start(32'h100, 16'd16, 4'd8, 4'd8);
        collect(50, 1, 3, 0, 0);
        checks++; if (n_wr !== 16) $display("FAIL bp_count: got %0d want 16", n_wr); else passed++;
        checks++; if (n_st !== 3) $display("FAIL bp_stalls: got %0d want 3", n_st); else passed++;
        for (int j = 0; j < 3; j++) begin
            checks++; if (sa[j] !== 32'h104) $display("FAIL bp_hold_addr[%0d]: got %h want 104", j, sa[j]); else passed++;
            checks++; if (sd[j] !== exp_data(0, 1)) $display("FAIL bp_hold_data[%0d]: got %h want %h", j, sd[j], exp_data(0, 1)); else passed++;
        end
        checks++; if (wa[1] !== 32'h104) $display("FAIL bp_addr1: got %h want 104", wa[1]); else passed++;
        checks++; if (wa[2] !== 32'h110) $display("FAIL bp_addr2: got %h want 110", wa[2]); else passed++;
        checks++; if (done_cyc !== 20) $display("FAIL bp_done_cycle: got %0d want 20", done_cyc); else passed++;
    endtask

    // 3 rows x 6 columns: half 1 carries only two valid lanes.
    task automatic test_edge_tile;
        logic [AW-1:0] ea;
        logic [L-1:0]  em;
        fill_out(0);
        issue_start(32'h200, 16'd20, 4'd3, 4'd6);
        collect(30, -1, 0, 0, 0);
        checks++; if (n_wr !== 6) $display("FAIL edge_count: got %0d want 6", n_wr); else passed++;
        for (int i = 0; i < 6; i++) begin
            ea = 32'h200 + 32'((i / 2) * 20 + (i % 2) * 4);
            em = (i % 2 == 1) ? 4'b0011 : 4'b1111;
            checks++; if (wa[i] !== ea) $display("FAIL edge_addr[%0d]: got %h want %h", i, wa[i], ea); else passed++;
            checks++; if (wm[i] !== em) $display("FAIL edge_mask[%0d]: got %b want %b", i, wm[i], em); else passed++;
            checks++; if (wd[i] !== exp_data(i / 2, i % 2)) $display("FAIL edge_data[%0d]: got %h want %h", i, wd[i], exp_data(i / 2, i % 2)); else passed++;
        end
        checks++; if (done_cyc !== 7) $display("FAIL edge_done_cycle: got %0d want 7", done_cyc); else passed++;
    endtask

    // Two columns: one write per row, never a second half.
    task automatic test_narrow;
        fill_out(0);
        issue_start(32'h0, 16'd8, 4'd8, 4'd2);
        collect(30, -1, 0, 0, 0);
        checks++; if (n_wr !== 8) $display("FAIL narrow_count: got %0d want 8", n_wr); else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++; if (wa[i] !== 32'(i * 8)) $display("FAIL narrow_addr[%0d]: got %h want %h", i, wa[i], 32'(i * 8)); else passed++;
            checks++; if (wm[i] !== 4'b0011) $display("FAIL narrow_mask[%0d]: got %b want 0011", i, wm[i]); else passed++;
            checks++; if (wd[i] !== exp_data(i, 0)) $display("FAIL narrow_data[%0d]: got %h want %h", i, wd[i], exp_data(i, 0)); else passed++;
        end
        checks++; if (done_cyc !== 9) $display("FAIL narrow_done_cycle: got %0d want 9", done_cyc); else passed++;
    endtask

    // Zero rows, zero columns, and oversize counts that clamp to 8.
    task automatic test_degenerate;
        issue_start(32'h40, 16'd8, 4'd0, 4'd8);
        collect(10, -1, 0, 0, 0);
        checks++; if (n_wr !== 0) $display("FAIL zero_rows_count: got %0d want 0", n_wr); else passed++;
        checks++; if (done_cyc !== 1) $display("FAIL zero_rows_done: got %0d want 1", done_cyc); else passed++;
        issue_start(32'h40, 16'd8, 4'd5, 4'd0);
        collect(10, -1, 0, 0, 0);
        checks++; if (n_wr !== 0) $display("FAIL zero_cols_count: got %0d want 0", n_wr); else passed++;
        checks++; if (done_cyc !== 1) $display("FAIL zero_cols_done: got %0d want 1", done_cyc); else passed++;
        fill_out(0);
        issue_start(32'h1000, 16'd16, 4'd15, 4'd12);
        collect(40, -1, 0, 0, 0);
        checks++; if (n_wr !== 16) $display("FAIL clamp_count: got %0d want 16", n_wr); else passed++;
        checks++; if (wa[15] !== 32'h1074) $display("FAIL clamp_last_addr: got %h want 1074", wa[15]); else passed++;
        checks++; if (wm[15] !== 4'b1111) $display("FAIL clamp_mask: got %b want 1111", wm[15]); else passed++;
    endtask

    // start pulsed mid-WRITE and in DONE with new inputs: must not recapture or restart.
    task automatic test_start_ignored;
        fill_out(0);
        issue_start(32'h100, 16'd16, 4'd8, 4'd8);
        base_C = 32'h900; rows_valid = 4'd2; cols_valid = 4'd2;
        collect(40, -1, 0, 6, 17);
        checks++; if (n_wr !== 16) $display("FAIL ign_count: got %0d want 16", n_wr); else passed++;
        checks++; if (wa[6] !== 32'h130) $display("FAIL ign_addr6: got %h want 130", wa[6]); else passed++;
        checks++; if (wa[15] !== 32'h174) $display("FAIL ign_addr15: got %h want 174", wa[15]); else passed++;
        checks++; if (done_cyc !== 17) $display("FAIL ign_done_cycle: got %0d want 17", done_cyc); else passed++;
        checks++; if (busy_after !== 1'b0) $display("FAIL ign_done_restart: got busy %0b want 0", busy_after); else passed++;
    endtask

    // Reset during the 5th write, then a clean restart from base_C.
    task automatic test_reset_mid;
        int stray;
        fill_out(0);
        issue_start(32'h100, 16'd16, 4'd8, 4'd8);
        repeat (4) begin @(posedge clock); #1; end
        checks++; if (write_addr !== 32'h120) $display("FAIL rst_5th_addr: got %h want 120", write_addr); else passed++;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (write !== 1'b0) $display("FAIL rst_mid_write: got %0b want 0", write); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %0b want 0", busy); else passed++;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            if (write || done) stray++;
            @(posedge clock); #1;
        end
        checks++; if (stray !== 0) $display("FAIL rst_stray_activity: got %0d want 0", stray); else passed++;
        issue_start(32'h300, 16'd16, 4'd8, 4'd8);
        collect(40, -1, 0, 0, 0);
        checks++; if (n_wr !== 16) $display("FAIL rst_restart_count: got %0d want 16", n_wr); else passed++;
        checks++; if (wa[0] !== 32'h300) $display("FAIL rst_restart_addr: got %h want 300", wa[0]); else passed++;
        checks++; if (wd[0] !== exp_data(0, 0)) $display("FAIL rst_restart_data: got %h want %h", wd[0], exp_data(0, 0)); else passed++;
        checks++; if (done_cyc !== 17) $display("FAIL rst_restart_done: got %0d want 17", done_cyc); else passed++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
        base_C = '0; dim_col_C = '0; rows_valid = '0; cols_valid = '0;
        fill_out(0);
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clock); #1;
        test_full_tile();
        test_backpressure();
        test_edge_tile();
        test_narrow();
        test_degenerate();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
